// File: rtl/handshake_source_fifo_pkg.sv
// Shared definitions for the req/ack dataflow handshake blocks.
// handshake_source_fifo uses this package today. Future handshake_sink
// blocks are meant to reuse the same constants and types.
package handshake_source_fifo_pkg;

    // ack is high for exactly this many cycles per delivered word.
    localparam int ACK_PULSE_WIDTH = 1;

    // Minimum number of cycles between two ack rising edges.
    localparam int MIN_ACK_SPACING = 2;

    // Default data word width. Blocks that take a data_width parameter
    // should default to this value.
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Width of the delivered-word counter.
    localparam int COUNT_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_word_t;
    typedef logic [COUNT_WIDTH-1:0]        xfer_count_t;

    // FIFO operation performed on one clock edge.
    typedef struct packed {
        logic push;
        logic pop;
    } fifo_op_t;

endpackage

// File: rtl/handshake_source_fifo_fifo_regfile.sv
// depth x data_width register array.
// One synchronous write port and one asynchronous read port.
module fifo_regfile #(
    parameter int data_width = 32,
    parameter int depth      = 16,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem_q [depth];

    // Store the write word at waddr.
    // NOTE: the array has no reset on purpose. The pointers and level decide
    // which entries are valid, so a reset would only add a large fan-out and
    // still leave nothing that could be read back.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The read is combinational. The parent registers the result into dout.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_source_fifo.sv
// Responder for the req/ack dataflow handshake.
// A host valid/ready stream fills a FIFO. Each req from the dataflow
// in_N operator is answered with a one-cycle ack pulse, and dout is
// updated on the same edge as that pulse.
module handshake_source_fifo
    import handshake_source_fifo_pkg::*;
#(
    parameter int data_width = 32,
    parameter int depth      = 16,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [data_width-1:0] wr_data,
    input  logic                  req,
    output logic                  ack,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   level,
    output logic [31:0]           count
);

    localparam logic [addr_width:0] FULL_LEVEL = (addr_width + 1)'(depth);

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   level_q,  level_d;
    logic                  ack_q,    ack_d;
    logic [data_width-1:0] dout_q,   dout_d;
    xfer_count_t           count_q,  count_d;

    logic                  full;
    logic [data_width-1:0] rd_word;
    fifo_op_t              op;

    // full is decoded straight from the level register. This lets a full
    // FIFO refuse a write in the same cycle, with no extra register.
    assign full  = (level_q == FULL_LEVEL);

    // The ~ack_q term keeps ack a single-cycle pulse. It also enforces the
    // two-cycle spacing the requester expects.
    assign op.push = wr_valid & ~full;
    assign op.pop  = req & ~ack_q & (level_q != '0);

    fifo_regfile #(
        .data_width (data_width),
        .depth      (depth)
    ) u_regfile (
        .clk   (clk),
        .we    (op.push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    // Next-state logic for the pointers, level and the ack/dout pair.
    // NOTE: every _d signal gets its hold value before any branch. This way
    // no path leaves a signal unassigned, and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = 1'b0;
        dout_d   = dout_q;
        count_d  = count_q;

        // Depth is a power of two, so the pointers wrap by overflow.
        if (op.push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (op.pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            ack_d    = 1'b1;
            dout_d   = rd_word;
            count_d  = count_q + 1'b1;
        end

        // A push and a pop on the same edge cancel out in the level.
        case (op)
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // State register. Reset is asynchronous, so an in-flight ack is
    // cleared without waiting for a clock edge.
    // NOTE: registers use non-blocking assignments. All flops then sample
    // the same pre-edge values, whatever order the simulator runs them in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ack_q    <= 1'b0;
            dout_q   <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            count_q  <= count_d;
        end
    end

    assign wr_ready = ~full;
    assign ack      = ack_q;
    assign dout     = dout_q;
    assign level    = level_q;
    assign count    = count_q;

endmodule

// File: tb/tb_handshake_source_fifo.sv
// Directed self-checking bench for handshake_source_fifo, built with depth=4.
// Inputs are driven and outputs are sampled on the falling edge of clk.
module tb_handshake_source_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          req;
    logic          ack;
    logic [DW-1:0] dout;
    logic [AW:0]   level;
    logic [31:0]   count;

    int total = 0;
    int bad   = 0;

    handshake_source_fifo #(
        .data_width (DW),
        .depth      (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .req      (req),
        .ack      (ack),
        .dout     (dout),
        .level    (level),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold req high until one ack arrives, check dout, then drop req.
    task automatic pop_one(input logic [DW-1:0] exp, input string name);
        bit got = 0;
        req = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s: no ack within 10 cycles", name);
        end else if (dout !== exp) begin
            bad++;
            $display("FAIL %s: dout=%0d expected %0d", name, dout, exp);
        end
        req = 1'b0;
        step();
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse: ack=%b expected 0", name, ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_ack: ack=%b expected 0", ack);
            end
        end
        total++;
        if (level !== 3'd0) begin bad++; $display("FAIL reset_level: level=%0d expected 0", level); end
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: wr_ready=%b expected 1", wr_ready); end
        total++;
        if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout: dout=%0d expected 0", dout); end
        total++;
        if (count !== 32'd0) begin bad++; $display("FAIL reset_count: count=%0d expected 0", count); end
        // After release the FIFO is still empty, so req must not be acked.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL empty_req_ack: ack=%b expected 0", ack);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_ordered();
        logic        exp_ack  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_dout [7] = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd7, 32'd7, 32'd7};
        wr_valid = 1'b1;
        for (int v = 5; v <= 7; v++) begin
            wr_data = DW'(v);
            step();
        end
        wr_valid = 1'b0;
        total++;
        if (level !== 3'd3) begin bad++; $display("FAIL ordered_fill: level=%0d expected 3", level); end
        // With req held high the ~ack gate alone sets the pulse spacing.
        req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (ack !== exp_ack[i] || dout !== exp_dout[i]) begin
                bad++;
                $display("FAIL ordered_cycle%0d: ack=%b dout=%0d expected ack=%b dout=%0d",
                         i, ack, dout, exp_ack[i], exp_dout[i]);
            end
        end
        req = 1'b0;
        total++;
        if (count !== 32'd3) begin bad++; $display("FAIL ordered_count: count=%0d expected 3", count); end
        total++;
        if (level !== 3'd0) begin bad++; $display("FAIL ordered_level: level=%0d expected 0", level); end
    endtask

    task automatic test_full();
        wr_valid = 1'b1;
        for (int v = 10; v <= 13; v++) begin
            wr_data = DW'(v);
            step();
        end
        wr_data = 32'd14;
        total++;
        if (wr_ready !== 1'b0 || level !== 3'd4) begin
            bad++;
            $display("FAIL full_flag: wr_ready=%b level=%0d expected 0/4", wr_ready, level);
        end
        step();
        total++;
        if (wr_ready !== 1'b0 || level !== 3'd4) begin
            bad++;
            $display("FAIL full_holdoff: wr_ready=%b level=%0d expected 0/4", wr_ready, level);
        end
        // The pop proceeds while full. The push of 14 stays blocked on this edge.
        req = 1'b1;
        step();
        req = 1'b0;
        total++;
        if (ack !== 1'b1 || dout !== 32'd10) begin
            bad++;
            $display("FAIL full_pop: ack=%b dout=%0d expected 1/10", ack, dout);
        end
        total++;
        if (wr_ready !== 1'b1 || level !== 3'd3) begin
            bad++;
            $display("FAIL full_reopen: wr_ready=%b level=%0d expected 1/3", wr_ready, level);
        end
        step();
        wr_valid = 1'b0;
        total++;
        if (level !== 3'd4) begin bad++; $display("FAIL full_accept14: level=%0d expected 4", level); end
        pop_one(32'd11, "full_rd11");
        pop_one(32'd12, "full_rd12");
        pop_one(32'd13, "full_rd13");
        pop_one(32'd14, "full_rd14");
        total++;
        if (level !== 3'd0 || count !== 32'd8) begin
            bad++;
            $display("FAIL full_end: level=%0d count=%0d expected 0/8", level, count);
        end
    endtask

    task automatic test_stream();
        int  wr_idx = 0;
        int  rd_idx = 0;
        int  wait_n = 0;
        int  cycles = 0;
        bit  will_push;
        bit  prev_ack = 0;
        logic [31:0] start_count = count;
        wr_valid = 1'b1;
        wr_data  = 32'd0;
        req      = 1'b1;
        while (rd_idx < 100 && cycles < 2000) begin
            will_push = wr_valid && wr_ready;
            step();
            cycles++;
            if (will_push) wr_idx++;
            wr_valid = (wr_idx < 100);
            wr_data  = DW'(wr_idx);
            if (ack) begin
                total++;
                if (prev_ack || dout !== DW'(rd_idx)) begin
                    bad++;
                    $display("FAIL stream_word%0d: dout=%0d back_to_back=%0b expected %0d",
                             rd_idx, dout, prev_ack, rd_idx);
                end
                rd_idx++;
                req    = 1'b0;
                wait_n = 2;
            end else if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) req = 1'b1;
            end
            prev_ack = ack;
        end
        req      = 1'b0;
        wr_valid = 1'b0;
        step();
        total++;
        if (rd_idx != 100) begin
            bad++;
            $display("FAIL stream_timeout: got %0d words expected 100", rd_idx);
        end
        total++;
        if (count - start_count !== 32'd100 || level !== 3'd0) begin
            bad++;
            $display("FAIL stream_end: delivered=%0d level=%0d expected 100/0",
                     count - start_count, level);
        end
    endtask

    task automatic test_latency();
        req      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'd42;
        step();
        wr_valid = 1'b0;
        total++;
        if (ack !== 1'b0 || level !== 3'd1) begin
            bad++;
            $display("FAIL latency_edgeN: ack=%b level=%0d expected 0/1", ack, level);
        end
        step();
        total++;
        if (ack !== 1'b1 || dout !== 32'd42) begin
            bad++;
            $display("FAIL latency_edgeN1: ack=%b dout=%0d expected 1/42", ack, dout);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1;
        for (int v = 20; v <= 23; v++) begin
            wr_data = DW'(v);
            step();
        end
        wr_valid = 1'b0;
        req      = 1'b1;
        step();
        req = 1'b0;
        total++;
        if (ack !== 1'b1 || level !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_setup: ack=%b level=%0d expected 1/3", ack, level);
        end
        // Assert reset away from any clock edge.
        #2 rst = 1'b1;
        #1;
        total++;
        if (ack !== 1'b0 || level !== 3'd0 || count !== 32'd0 || dout !== 32'd0 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_async: ack=%b level=%0d count=%0d dout=%0d wr_ready=%b expected 0/0/0/0/1",
                     ack, level, count, dout, wr_ready);
        end
        step();
        rst = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 32'd9;
        step();
        wr_valid = 1'b0;
        pop_one(32'd9, "rstmid_fresh");
        total++;
        if (count !== 32'd1 || level !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_end: count=%0d level=%0d expected 1/0", count, level);
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_full();
        test_stream();
        test_latency();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
